rdy_vld_merge: RTL

RDY_VLD_MERGE -- requirements
Module: rdy_vld_merge

---
 rtl/rdy_vld_merge.sv | 116 +++++++++++
 1 files changed

// File: rtl/rdy_vld_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rdy_vld_merge: N_CH rdy/vld inputs, each with a private FIFO, merged by  |
// | a round-robin arbiter into one registered rdy/vld output stream.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rdy_vld_merge #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 2,
  parameter int DEPTH  = 4,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_vld,
  output logic [N_CH-1:0]          in_rdy,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full    = CNT_W'(DEPTH);
  localparam logic [CH_W-1:0]  c_last_ch = CH_W'(N_CH - 1);

  logic [N_CH-1:0]   w_nonempty;
  logic [N_CH-1:0]   w_push;
  logic [N_CH-1:0]   w_pop;
  logic [DATA_W-1:0] w_head [N_CH];
  logic              w_load;
  logic [CH_W-1:0]   w_grant;

  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_last;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [CNT_W-1:0]  r_cnt;
      logic [PTR_W-1:0]  r_wptr;
      logic [PTR_W-1:0]  r_rptr;

      // Ready depends on the registered count only, so no path from vld/rdy inputs.
      assign in_rdy[gi]     = (r_cnt != c_full);
      assign w_nonempty[gi] = (r_cnt != '0);
      assign w_push[gi]     = in_vld[gi] & in_rdy[gi] & ~rst;
      assign w_pop[gi]      = w_load & (w_grant == CH_W'(gi));
      assign w_head[gi]     = r_mem[r_rptr];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt  <= '0;
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
          if (w_pop[gi])  r_rptr <= r_rptr + 1'b1;
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wptr] <= in_data[gi*DATA_W +: DATA_W];
      end
    end
  endgenerate

  assign w_load = (~r_out_vld | out_rdy) & (|w_nonempty);

  // Round-robin: scan upward from the channel after the last grant, wrapping at N_CH.
  always_comb begin : p_arb
    logic [CH_W-1:0] v_idx;
    logic            v_found;
    w_grant = '0;
    v_found = 1'b0;
    v_idx   = (r_last == c_last_ch) ? '0 : r_last + 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (!v_found && w_nonempty[v_idx]) begin
        w_grant = v_idx;
        v_found = 1'b1;
      end
      v_idx = (v_idx == c_last_ch) ? '0 : v_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_last     <= c_last_ch;
    end else if (w_load) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_head[w_grant];
      r_out_ch   <= w_grant;
      r_last     <= w_grant;
    end else if (out_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign out_vld  = r_out_vld;
  assign out_data = r_out_data;
  assign out_ch   = r_out_ch;

endmodule
`default_nettype wire
